// File: rtl/ysyx_24100005_lsu.sv
// rtl/ysyx_24100005_lsu.sv - multi-cycle load/store unit; LSU_MISALIGN_TRAP_EN selects trapping of misaligned accesses
module ysyx_24100005_lsu #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp_err
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit MISALIGN_TRAP = 1'b1;
`else
    localparam bit MISALIGN_TRAP = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t             state;
    logic               we_q;
    logic [2:0]         f3_q;
    logic [OFF_W-1:0]   off_q;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [NB-1:0]      mem_wmask_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;
    logic               mem_req_valid_q;
    logic               resp_valid_q;

    logic               legal;
    logic [NB-1:0]      lane_mask;
    logic [OFF_W-1:0]   align_mask;
    logic [OFF_W-1:0]   req_off;
    logic [OFF_W-1:0]   off_eff;
    logic               misaligned;
    logic [DATA_W-1:0]  raw;
    logic [DATA_W-1:0]  load_ext;

    assign req_ready     = rst && (state == S_IDLE);
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;

    // Decode the incoming request: legality, byte-lane mask and natural alignment.
    always_comb begin
        legal = 1'b0;
        case ({req_we, req_funct3})
            4'b0_000, 4'b0_001, 4'b0_010, 4'b0_100, 4'b0_101,
            4'b1_000, 4'b1_001, 4'b1_010: legal = 1'b1;
            4'b0_011, 4'b0_110, 4'b1_011: legal = (DATA_W == 64);
            default:                      legal = 1'b0;
        endcase
        lane_mask  = '0;
        align_mask = '0;
        case (req_funct3[1:0])
            2'd0:    begin lane_mask = NB'(8'h01); align_mask = '0;         end
            2'd1:    begin lane_mask = NB'(8'h03); align_mask = OFF_W'(1); end
            2'd2:    begin lane_mask = NB'(8'h0F); align_mask = OFF_W'(3); end
            default: begin lane_mask = NB'(8'hFF); align_mask = OFF_W'(7); end
        endcase
        req_off    = req_addr[OFF_W-1:0];
        misaligned = |(req_off & align_mask);
        off_eff    = req_off & ~align_mask;
    end

    // Shift the returned word down to its lane and extend to the bus width.
    always_comb begin
        raw = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_ext = DATA_W'($signed(raw[7:0]));
            3'b001:  load_ext = DATA_W'($signed(raw[15:0]));
            3'b010:  load_ext = DATA_W'($signed(raw[31:0]));
            3'b100:  load_ext = DATA_W'(raw[7:0]);
            3'b101:  load_ext = DATA_W'(raw[15:0]);
            3'b110:  load_ext = DATA_W'(raw[31:0]);
            default: load_ext = raw;
        endcase
    end

    // Request/response FSM; every output except req_ready comes from a flop here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            we_q            <= 1'b0;
            f3_q            <= '0;
            off_q           <= '0;
            cnt             <= '0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
            rdata_q         <= '0;
            err_q           <= 1'b0;
            mem_req_valid_q <= 1'b0;
            resp_valid_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        f3_q        <= req_funct3;
                        off_q       <= off_eff;
                        mem_addr_q  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mem_wdata_q <= req_wdata << {off_eff, 3'b000};
                        mem_wmask_q <= req_we ? (lane_mask << off_eff) : '0;
                        rdata_q     <= '0;
                        if (!legal || (MISALIGN_TRAP && misaligned)) begin
                            err_q        <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state        <= S_RESP;
                        end else begin
                            err_q           <= 1'b0;
                            mem_req_valid_q <= 1'b1;
                            state           <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        cnt             <= '0;
                        mem_req_valid_q <= 1'b0;
                        state           <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response arriving on the final counted cycle beats the timeout.
                    if (mem_resp_valid) begin
                        err_q        <= mem_resp_err;
                        rdata_q      <= (mem_resp_err || we_q) ? '0 : load_ext;
                        resp_valid_q <= 1'b1;
                        state        <= S_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err_q        <= 1'b1;
                        rdata_q      <= '0;
                        resp_valid_q <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        rdata_q      <= '0;
                        err_q        <= 1'b0;
                        resp_valid_q <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
